// File: rtl/shift_cmd_seq.sv
// -----------------------------------------------------------------------------
// shift_cmd_seq
//   Command sequencer for a WIDTH-bit bidirectional shift register. It accepts
//   one command per valid/ready handshake, then drives one load cycle followed
//   by cmd_cnt single-bit shift cycles. It keeps a shadow copy of the register
//   contents and pulses done when a command completes normally.
//
// Ports
//   clk        rising-edge clock, shared with the shift register
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE and not in reset)
//   cmd_data   value to load
//   cmd_dir    0 = shift left, 1 = shift right
//   cmd_cnt    number of single-bit shifts after the load
//   abort      terminate the in-flight command (honoured in LOAD and SHIFT)
//   en         load strobe to the shift register
//   left       left-shift strobe
//   right      right-shift strobe
//   load       load data (last captured command value)
//   busy       command in flight (LOAD, SHIFT, DONE)
//   done       one-cycle completion pulse
//   shadow_q   model of the shift register contents
// -----------------------------------------------------------------------------
module shift_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    output logic             en,
    output logic             left,
    output logic             right,
    output logic [WIDTH-1:0] load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] shadow_r;
    logic             dir_r;
    logic [CNT_W-1:0] rem_r;
    logic             accept_s;

    // Strobes are registered from the next state so each output is a clean
    // flop that matches a Moore decode of the registered state.
    logic             en_s;
    logic             left_s;
    logic             right_s;
    logic             busy_s;
    logic             done_s;
    logic             en_r;
    logic             left_r;
    logic             right_r;
    logic             busy_r;
    logic             done_r;

    assign cmd_ready = (state_r == ST_IDLE) & ~rst;
    assign accept_s  = cmd_valid & cmd_ready;

    // Next-state decode; abort wins over the normal SHIFT->DONE exit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_LOAD;
                else          state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort)                  state_s = ST_IDLE;
                else if (rem_r == CNT_ZERO) state_s = ST_DONE;
                else                        state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)                 state_s = ST_IDLE;
                else if (rem_r == CNT_ONE) state_s = ST_DONE;
                else                       state_s = ST_SHIFT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode of the state about to be entered (zero while in reset).
    always_comb begin
        en_s    = 1'b0;
        left_s  = 1'b0;
        right_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        if (rst) begin
            en_s    = 1'b0;
        end else begin
            case (state_s)
                ST_IDLE: begin
                    busy_s = 1'b0;
                end
                ST_LOAD: begin
                    en_s   = 1'b1;
                    busy_s = 1'b1;
                end
                ST_SHIFT: begin
                    left_s  = ~dir_r;
                    right_s = dir_r;
                    busy_s  = 1'b1;
                end
                ST_DONE: begin
                    done_s = 1'b1;
                    busy_s = 1'b1;
                end
                default: begin
                    busy_s = 1'b0;
                end
            endcase
        end
    end

    // State and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
            left_r  <= 1'b0;
            right_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            en_r    <= en_s;
            left_r  <= left_s;
            right_r <= right_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Command capture, remaining-shift counter and shadow of the register.
    // rem_r holds the captured count from accept onward, so LOAD can branch
    // on it directly; each SHIFT edge consumes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= {WIDTH{1'b0}};
            dir_r    <= 1'b0;
            rem_r    <= CNT_ZERO;
            shadow_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        data_r <= cmd_data;
                        dir_r  <= cmd_dir;
                        rem_r  <= cmd_cnt;
                    end else begin
                        data_r <= data_r;
                    end
                end
                ST_LOAD: begin
                    shadow_r <= data_r;
                end
                ST_SHIFT: begin
                    if (dir_r) shadow_r <= {1'b0, shadow_r[WIDTH-1:1]};
                    else       shadow_r <= {shadow_r[WIDTH-2:0], 1'b0};
                    rem_r <= rem_r - CNT_ONE;
                end
                default: begin
                    shadow_r <= shadow_r;
                end
            endcase
        end
    end

    assign en       = en_r;
    assign left     = left_r;
    assign right    = right_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign load     = data_r;
    assign shadow_q = shadow_r;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_cmd_seq
//   Directed plus randomized bench for shift_cmd_seq. A reference model tracks
//   each command as "cycle index within the command" and computes the shadow
//   value arithmetically from the loaded data and the number of shifts taken.
// -----------------------------------------------------------------------------
module tb_shift_cmd_seq;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_cnt;
    logic       abort;
    logic       en;
    logic       left;
    logic       right;
    logic [3:0] load;
    logic       busy;
    logic       done;
    logic [3:0] shadow_q;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_busy  = 1'b0;
    int         m_k     = 0;   // 0 = load cycle, 1..cnt = shifts, cnt+1 = done
    int         m_j     = 0;   // shifts applied since the load
    int         m_cnt   = 0;
    bit         m_dir   = 1'b0;
    logic [3:0] m_data  = 4'd0;
    logic [3:0] m_load  = 4'd0;
    logic [3:0] m_shadow = 4'd0;

    shift_cmd_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .abort     (abort),
        .en        (en),
        .left      (left),
        .right     (right),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .shadow_q  (shadow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] shifted(input logic [3:0] d, input bit dir, input int j);
        int v;
        v = int'(d);
        if (dir) v = v >> j;
        else     v = (v << j) & 15;
        return v[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then check.
    task automatic step();
        bit   e_en, e_l, e_r, e_done;
        int   ones;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_k = 0; m_j = 0; m_cnt = 0; m_dir = 1'b0;
            m_data = 4'd0; m_load = 4'd0; m_shadow = 4'd0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_data = cmd_data; m_load = cmd_data; m_dir = cmd_dir;
                m_cnt = int'(cmd_cnt); m_busy = 1'b1; m_k = 0;
            end
        end else if (m_k == 0) begin
            m_j = 0;
            m_shadow = shifted(m_data, m_dir, m_j);
            if (abort) m_busy = 1'b0;
            else       m_k = 1;
        end else if (m_k <= m_cnt) begin
            m_j++;
            m_shadow = shifted(m_data, m_dir, m_j);
            if (abort) m_busy = 1'b0;
            else       m_k++;
        end else begin
            m_busy = 1'b0;
        end
        #1;
        e_en   = m_busy && (m_k == 0);
        e_l    = m_busy && (m_k >= 1) && (m_k <= m_cnt) && !m_dir;
        e_r    = m_busy && (m_k >= 1) && (m_k <= m_cnt) && m_dir;
        e_done = m_busy && (m_k == m_cnt + 1);
        chk("en",        32'(en),        32'(e_en));
        chk("left",      32'(left),      32'(e_l));
        chk("right",     32'(right),     32'(e_r));
        chk("done",      32'(done),      32'(e_done));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !rst));
        chk("load",      32'(load),      32'(m_load));
        chk("shadow_q",  32'(shadow_q),  32'(m_shadow));
        ones = int'(en) + int'(left) + int'(right);
        chk("strobe_excl", 32'(ones <= 1), 32'd1);
    endtask

    // Present a command, wait for acceptance, then run it to completion.
    // abort_at / rst_at select the in-command cycle index to hit (-1 = never).
    task automatic run_cmd(input logic [3:0] d, input bit dir, input logic [2:0] cnt,
                           input int abort_at, input int rst_at, input bit hold_valid);
        int guard;
        rst = 1'b0; abort = 1'b0;
        cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_cnt = cnt;
        guard = 0;
        while (!m_busy && guard < 8) begin
            step();
            guard++;
        end
        if (!m_busy) chk("accept_timeout", 32'd0, 32'd1);
        guard = 0;
        while (m_busy && guard < 40) begin
            cmd_valid = hold_valid;
            cmd_data  = 4'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_cnt   = 3'($urandom);
            if (m_k == m_cnt + 1) abort = 1'($urandom);
            else                  abort = (m_k == abort_at);
            rst = (m_k == rst_at);
            step();
            guard++;
        end
        if (m_busy) chk("complete_timeout", 32'd0, 32'd1);
        rst = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_data = 4'hA; cmd_dir = 1'b0;
        cmd_cnt = 3'd1; abort = 1'b0;
        // Commands offered during reset are never accepted.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0; cmd_valid = 1'b0;
        step();

        run_cmd(4'b1011, 1'b0, 3'd2, -1, -1, 1'b0);
        step();
        run_cmd(4'b1011, 1'b1, 3'd3, -1, -1, 1'b0);
        run_cmd(4'b0110, 1'b0, 3'd0, -1, -1, 1'b0);
        step();
        run_cmd(4'b1111, 1'b0, 3'd7, -1, -1, 1'b0);
        run_cmd(4'b1001, 1'b0, 3'd3,  2, -1, 1'b0);
        step();
        // Two queued commands with valid held; reset lands mid-SHIFT of the first.
        run_cmd(4'b1101, 1'b0, 3'd5, -1,  2, 1'b1);
        step();
        run_cmd(4'b0111, 1'b1, 3'd2, -1, -1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] c;
            int         ab;
            c  = 3'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(c))) : -1;
            run_cmd(4'($urandom), 1'($urandom), c, ab, -1, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b0;
                abort = 1'($urandom);
                step();
                abort = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit bidirectional shift register and drives its en/left/right/load inputs. It accepts one command per valid/ready handshake, where a command is a load value, a direction and a shift count. It then issues one load cycle followed by N single-bit shift cycles. It keeps a shadow copy of the register contents and pulses done when the command completes.

Parameters:
WIDTH, 4, data width of the load value and the shadow register; must match the shift register width.
CNT_W, 3, width of the shift-count field (maximum count 2^CNT_W-1).

Ports:
clk  input  1  rising-edge clock, shared with the shift register
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_data  input  WIDTH  value to load
cmd_dir  input  1  0 = shift left, 1 = shift right
cmd_cnt  input  CNT_W  number of single-bit shifts after the load
abort  input  1  terminate the in-flight command
en  output  1  load strobe to the shift register
left  output  1  left-shift strobe
right  output  1  right-shift strobe
load  output  WIDTH  load data to the shift register
busy  output  1  command in flight
done  output  1  one-cycle completion pulse
shadow_q  output  WIDTH  model of the shift register contents

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, en=left=right=0, load=0, busy=0, done=0, shadow_q=0, internal data/dir/count registers cleared.
- cmd_ready = (state==IDLE) & ~rst. A command presented while rst is high is never accepted.
- States: IDLE, LOAD, SHIFT, DONE. Outputs are Moore-decoded from registered state and data.
- IDLE:
  - cmd_ready=1, all strobes 0.
  - On cmd_valid&cmd_ready at edge T: capture cmd_data, cmd_dir, cmd_cnt, then go to LOAD.
- LOAD (cycle T+1):
  - en=1, load=captured data.
  - At the edge, shadow_q<=captured data and remaining<=captured count.
  - Next state is DONE if count==0, else SHIFT.
- SHIFT:
  - left=~dir, right=dir.
  - At each edge, shadow_q shifts one bit in that direction with zero fill, and remaining decrements.
  - Leave to DONE at the edge where remaining==1.
  - Exactly cmd_cnt shift cycles are issued: T+2 through T+1+cnt.
- DONE: done=1 for exactly one cycle (T+2+cnt), busy still 1, cmd_ready=0; next state IDLE.
- Back-to-back: the earliest next accept is the cycle after DONE. Throughput is one command per cnt+3 cycles.
- busy=1 in LOAD, SHIFT and DONE.
- Mutual exclusion: at most one of en, left, right is high in any cycle. left and right are never high together.
- load holds its last captured value outside LOAD; en=0 masks it.
- Shadow tracking: shadow_q updates on the same edge the shift register does. After any edge it equals q of a shift register driven by these outputs and reset together with the sequencer.
- Counts of WIDTH or more are legal; the extra shifts leave shadow_q=0.
- abort in LOAD or SHIFT:
  - The strobe shown in that cycle still takes effect, and shadow_q updates for it.
  - At that edge the state goes to IDLE with no done pulse.
- abort in IDLE or DONE: ignored.
- abort takes precedence over normal SHIFT→DONE exit on the same edge.
- rst mid-operation: at the next edge all state returns to reset values; no done pulse.
- cmd_valid high while not ready: the command is held by upstream and not captured. cmd_data may change freely until accepted.

Test Plan:
- Reset, then cmd 1011/left/cnt=2 accepted at T -> en=1 load=1011 at T+1; left=1 at T+2,T+3; shadow_q 1011→0110→1100; done at T+4 only.
- cmd 1011/right/cnt=3 -> right high 3 cycles; shadow_q 0101, 0010, 0001; done at T+5; left never high.
- cmd 0110/cnt=0 -> single en cycle, no shift strobes, shadow_q=0110, done at T+2, cmd_ready back to 1 at T+3.
- cmd 1111/left/cnt=7 -> shadow_q reaches 0000 after 4 shifts and stays 0; 7 left cycles; done at T+9.
- abort asserted during the 2nd shift of cmd 1001/left/cnt=3 -> two left strobes total, shadow_q=0100, no done, IDLE/cmd_ready=1 next cycle.
- cmd_valid held high with two queued commands; rst pulsed mid-SHIFT of the first -> all outputs 0 after the edge, no done; next accept only after rst deasserts; no cycle ever has two of en/left/right high.
